// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply/divide unit for the execute stage.
// Multiply is radix-2 shift-add and divide is restoring division. Both work on
// operand magnitudes, take one bit per cycle, and apply signs at completion.
// Every operation takes WIDTH+1 edges from start to result.
// Optional feature: define MULTDIV_REMAINDER_EN to add the data_remainder
// output and its register.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] data_operandA,
  input  logic signed [WIDTH-1:0] data_operandB,
  input  logic                    ctrl_MULT,
  input  logic                    ctrl_DIV,
  input  logic                    ctrl_FLUSH,
  output logic [WIDTH-1:0]        data_result,
  output logic                    data_exception,
  output logic                    data_resultRDY,
  output logic                    busy
`ifdef MULTDIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0]        data_remainder
`endif
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0]        mag_m;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]        hi, lo;  // {product} for MUL, {remainder, quotient} for DIV
  logic                    start, start_mul, running, iter, finish, neg;
  logic [WIDTH:0]          mul_sum, div_diff;
  logic signed [2*WIDTH-1:0] prod_s;

  // Magnitude of a two's-complement value. MIN maps to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  // Apply the sign to a magnitude.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic n);
    return n ? -mag : mag;
  endfunction

  // The product overflows WIDTH bits unless its top WIDTH+1 bits are all equal.
  function automatic logic mul_overflow(input logic signed [2*WIDTH-1:0] p);
    return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
  endfunction

  assign running   = (state == MUL) || (state == DIV);
  assign start     = (ctrl_MULT || ctrl_DIV) && ((state == IDLE) || (state == DONE)) && !ctrl_FLUSH;
  assign start_mul = ctrl_MULT;
  assign iter      = running && (cnt != '0);
  assign finish    = running && (cnt == '0) && !ctrl_FLUSH;
  assign neg       = op_a[WIDTH-1] ^ op_b[WIDTH-1];

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_m} : '0);
  assign div_diff = {hi, lo[WIDTH-1]} - {1'b0, mag_m};
  assign prod_s   = neg ? -$signed({hi, lo}) : $signed({hi, lo});

  // Next-state logic: start from IDLE/DONE, finish when the counter is spent; flush wins.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: if (start) state_n = start_mul ? MUL : DIV;
      MUL, DIV:   if (cnt == '0) state_n = DONE;
      default:    state_n = IDLE;
    endcase
    if (ctrl_FLUSH) state_n = IDLE;
  end

  // Control, counter and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else begin
      state          <= state_n;
      busy           <= (state_n == MUL) || (state_n == DIV);
      data_resultRDY <= finish;
      if (start)     cnt <= CNT_W'(WIDTH);
      else if (iter) cnt <= cnt - CNT_W'(1);
      if (finish) begin
        if (state == MUL) begin
          data_result    <= prod_s[WIDTH-1:0];
          data_exception <= mul_overflow(prod_s);
`ifdef MULTDIV_REMAINDER_EN
          data_remainder <= '0;
`endif
        end else if (op_b == '0) begin
          data_result    <= '0;
          data_exception <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
          data_remainder <= op_a;
`endif
        end else if ((op_a == MIN_VAL) && (op_b == '1)) begin
          data_result    <= MIN_VAL;
          data_exception <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
          data_remainder <= '0;
`endif
        end else begin
          data_result    <= apply_sign(lo, neg);
          data_exception <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
          data_remainder <= apply_sign(hi, op_a[WIDTH-1]);
`endif
        end
      end
    end
  end

  // Datapath: latch the operands on start, then do one shift-add or restoring step per cycle.
  always_ff @(posedge clock) begin
    if (start) begin
      op_a  <= data_operandA;
      op_b  <= data_operandB;
      mag_m <= start_mul ? abs_mag(data_operandA) : abs_mag(data_operandB);
      hi    <= '0;
      lo    <= start_mul ? abs_mag(data_operandB) : abs_mag(data_operandA);
    end else if (iter) begin
      if (state == MUL) begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end else begin
        hi <= div_diff[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : div_diff[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], ~div_diff[WIDTH]};
      end
    end
  end

endmodule
